diff_stream: RTL and testbench

Streaming, parametrised successor to the team's combinational differential word encoder. Accepts DNA-style words of N radix-2^W digits per beat over a valid/ready handshake. Per sequence it either differentially encodes (digit minus preceding digit, mod 2^W) or decodes (running sum, mod 2^W). The preceding digit is carried across beat boundaries, so a multi-word sequence behaves exactly like one long word. Sits between the sequence source and the downstream packer in the DNA codec path.

---
 rtl/diff_stream_pkg.sv | 39 +++
 rtl/diff_stream_if.sv | 30 +++
 rtl/diff_core.sv | 49 ++++
 rtl/diff_stream.sv | 112 +++++++++++
 tb/tb_diff_stream.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/diff_stream_pkg.sv
// diff_pkg: types and digit arithmetic for the diff_stream block.
//   mode_e  : per-sequence operation (ENCODE = difference, DECODE = running sum)
//   state_e : stream state (IDLE = no open sequence, ACTIVE = seed and mode valid)
//   mod_sub / mod_add : wraparound arithmetic on digits up to DIGIT_W_MAX bits.
//   The caller passes the actual digit width and truncates the result.
package diff_pkg;

    typedef enum logic {
        ENCODE = 1'b0,
        DECODE = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int unsigned DIGIT_W_MAX = 8;

    typedef logic [DIGIT_W_MAX-1:0] digit_t;

    // Keeps only the low w bits; w = DIGIT_W_MAX yields all ones.
    function automatic digit_t digit_mask(input int unsigned w);
        digit_t all_ones;
        all_ones = '1;
        return ~(all_ones << w);
    endfunction

    function automatic digit_t mod_sub(input digit_t a, input digit_t b,
                                       input int unsigned w);
        return (a - b) & digit_mask(w);
    endfunction

    function automatic digit_t mod_add(input digit_t a, input digit_t b,
                                       input int unsigned w);
        return (a + b) & digit_mask(w);
    endfunction

endpackage

// File: rtl/diff_stream_if.sv
// diff_stream_if: groups the input and output valid/ready streams plus the
// word counter of diff_stream.
//   slave  : view used by diff_stream (consumes in_*, produces out_*)
//   master : view used by the sequence source / downstream packer
interface diff_stream_if #(
    parameter int N     = 8,
    parameter int W     = 2,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_word;
    logic             in_sop;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_word;
    logic             out_sop;
    logic [CNT_W-1:0] word_cnt;

    modport slave (
        input  in_valid, in_word, in_sop, in_mode, out_ready,
        output in_ready, out_valid, out_word, out_sop, word_cnt
    );

    modport master (
        output in_valid, in_word, in_sop, in_mode, out_ready,
        input  in_ready, out_valid, out_word, out_sop, word_cnt
    );
endinterface

// File: rtl/diff_core.sv
// diff_core: combinational differential encoder/decoder for one word.
//   word_i       : N digits, digit 0 at the most significant end
//   mode_i       : ENCODE or DECODE
//   seed_i       : digit preceding digit 0 (from the previous word)
//   seed_valid_i : 0 on the first word of a sequence (digit 0 passes through)
//   word_o       : result word, same digit ordering
//   seed_o       : seed for the next word (last original digit when encoding,
//                  last reconstructed digit when decoding)
module diff_core
    import diff_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic [N*W-1:0] word_i,
    input  mode_e          mode_i,
    input  logic [W-1:0]   seed_i,
    input  logic           seed_valid_i,
    output logic [N*W-1:0] word_o,
    output logic [W-1:0]   seed_o
);

    always_comb begin
        digit_t       prev;
        logic [W-1:0] d_in;
        logic [W-1:0] d_out;

        word_o = '0;
        d_in   = '0;
        d_out  = '0;
        // A missing seed behaves as zero, which makes digit 0 pass through.
        prev   = seed_valid_i ? digit_t'(seed_i) : '0;

        for (int k = 0; k < N; k++) begin
            d_in = word_i[(N-1-k)*W +: W];
            if (mode_i == ENCODE) begin
                d_out = W'(mod_sub(digit_t'(d_in), prev, W));
                prev  = digit_t'(d_in);
            end else begin
                d_out = W'(mod_add(digit_t'(d_in), prev, W));
                prev  = digit_t'(d_out);
            end
            word_o[(N-1-k)*W +: W] = d_out;
        end

        seed_o = W'(prev);
    end

endmodule

// File: rtl/diff_stream.sv
// diff_stream: streaming differential encoder/decoder with valid/ready
// handshake and one cycle of latency. The preceding digit is carried across
// beats so a multi-word sequence behaves like one long word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   s     : diff_stream_if.slave (in_* stream, out_* stream, word_cnt)
//
//   state  | meaning
//   IDLE   | no sequence open; next accepted beat starts one
//   ACTIVE | seed digit valid and mode latched for the open sequence
module diff_stream
    import diff_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 2,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    diff_stream_if.slave  s
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [W-1:0]     seed_q, seed_d;
    logic             out_valid_q, out_valid_d;
    logic [N*W-1:0]   out_word_q, out_word_d;
    logic             out_sop_q, out_sop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_ready;
    logic             accept;
    logic             sop_eff;
    mode_e            mode_eff;
    logic [N*W-1:0]   core_word;
    logic [W-1:0]     core_seed;

    // The output register can take a new beat whenever it is empty or being
    // drained this cycle, giving full throughput.
    assign in_ready = !out_valid_q || s.out_ready;
    assign accept   = s.in_valid && in_ready;

    // Any beat arriving with no open sequence starts one.
    assign sop_eff  = s.in_sop || (state_q == IDLE);
    assign mode_eff = sop_eff ? mode_e'(s.in_mode) : mode_q;

    diff_core #(
        .N (N),
        .W (W)
    ) u_core (
        .word_i       (s.in_word),
        .mode_i       (mode_eff),
        .seed_i       (seed_q),
        .seed_valid_i (!sop_eff),
        .word_o       (core_word),
        .seed_o       (core_seed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= ENCODE;
            seed_q      <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_sop_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_sop_q   <= out_sop_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_sop_d   = out_sop_q;
        cnt_d       = cnt_q;

        if (accept) begin
            state_d     = ACTIVE;
            mode_d      = mode_eff;
            seed_d      = core_seed;
            out_valid_d = 1'b1;
            out_word_d  = core_word;
            out_sop_d   = sop_eff;
            if (sop_eff) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (s.out_ready) begin
            // Counter and word stay visible after drain; only valid drops.
            out_valid_d = 1'b0;
        end
    end

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_word  = out_word_q;
    assign s.out_sop   = out_sop_q;
    assign s.word_cnt  = cnt_q;

endmodule

// File: tb/tb_diff_stream.sv
// tb_diff_stream: directed bench for diff_stream.
// Instance A: N=4, W=2, CNT_W=16 with hand-computed vectors.
// Instance B: N=8, W=3, CNT_W=2 for encode/decode loopback and counter saturation.
module tb_diff_stream;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    diff_stream_if #(.N(4), .W(2), .CNT_W(16)) ifa ();
    diff_stream_if #(.N(8), .W(3), .CNT_W(2))  ifb ();

    diff_stream #(.N(4), .W(2), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (ifa)
    );

    diff_stream #(.N(8), .W(3), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One beat into instance A; assumes out_ready is high so in_ready is high.
    task automatic beat_a(input logic [7:0] w, input logic sop, input logic mode);
        ifa.in_valid = 1'b1;
        ifa.in_word  = w;
        ifa.in_sop   = sop;
        ifa.in_mode  = mode;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic beat_b(input logic [23:0] w, input logic sop, input logic mode);
        ifb.in_valid = 1'b1;
        ifb.in_word  = w;
        ifb.in_sop   = sop;
        ifb.in_mode  = mode;
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
    endtask

    logic [23:0] orig [16];
    logic [23:0] enc  [16];
    logic        sopv [16];
    int          ecnt;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_word = '0; ifa.in_sop = 1'b0; ifa.in_mode = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_word = '0; ifb.in_sop = 1'b0; ifb.in_mode = 1'b0;
        ifb.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ifa.out_valid), 32'h0);
        chk("rst_word",  32'(ifa.out_word),  32'h0);
        chk("rst_sop",   32'(ifa.out_sop),   32'h0);
        chk("rst_cnt",   32'(ifa.word_cnt),  32'h0);
        chk("rst_ready", 32'(ifa.in_ready),  32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Encode [3,1,0,2] -> [3,2,3,2]; then [1,1,1,1] with seed 2 -> [3,0,0,0].
        // in_mode=1 on the second beat must be ignored (not a sop beat).
        beat_a(8'hD2, 1'b1, 1'b0);
        chk("enc0_valid", 32'(ifa.out_valid), 32'h1);
        chk("enc0_word",  32'(ifa.out_word),  32'hEE);
        chk("enc0_sop",   32'(ifa.out_sop),   32'h1);
        chk("enc0_cnt",   32'(ifa.word_cnt),  32'h1);
        beat_a(8'h55, 1'b0, 1'b1);
        chk("enc1_word",  32'(ifa.out_word),  32'hC0);
        chk("enc1_sop",   32'(ifa.out_sop),   32'h0);
        chk("enc1_cnt",   32'(ifa.word_cnt),  32'h2);

        // Decode [3,2,3,2] -> [3,1,0,2]; then [3,0,0,0] with seed 2 -> [1,1,1,1].
        beat_a(8'hEE, 1'b1, 1'b1);
        chk("dec0_word",  32'(ifa.out_word),  32'hD2);
        chk("dec0_sop",   32'(ifa.out_sop),   32'h1);
        chk("dec0_cnt",   32'(ifa.word_cnt),  32'h1);
        beat_a(8'hC0, 1'b0, 1'b0);
        chk("dec1_word",  32'(ifa.out_word),  32'h55);
        chk("dec1_cnt",   32'(ifa.word_cnt),  32'h2);
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(ifa.out_valid), 32'h0);

        // Stall: output held 3 cycles, queued beat waits, then streaming resumes.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_word   = 8'hD2;
        ifa.in_sop    = 1'b1;
        ifa.in_mode   = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_acc_word", 32'(ifa.out_word), 32'hEE);
        ifa.in_word = 8'h55;
        ifa.in_sop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_ready", 32'(ifa.in_ready),  32'h0);
            chk("stall_valid", 32'(ifa.out_valid), 32'h1);
            chk("stall_word",  32'(ifa.out_word),  32'hEE);
            chk("stall_cnt",   32'(ifa.word_cnt),  32'h1);
        end
        ifa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("resume1_word", 32'(ifa.out_word), 32'hC0);
        chk("resume1_cnt",  32'(ifa.word_cnt), 32'h2);
        // [0,3,2,1] with seed 1 -> [3,3,3,3]
        ifa.in_word = 8'h39;
        @(posedge clk);
        #1;
        chk("resume2_word",  32'(ifa.out_word),  32'hFF);
        chk("resume2_cnt",   32'(ifa.word_cnt),  32'h3);
        chk("resume2_valid", 32'(ifa.out_valid), 32'h1);
        ifa.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("resume_drain", 32'(ifa.out_valid), 32'h0);
        chk("resume_cnt",   32'(ifa.word_cnt),  32'h3);

        // Reset mid-sequence drops output and seed; next non-sop beat opens a
        // fresh sequence: [1,1,1,1] encodes to [1,0,0,0].
        beat_a(8'hD2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", 32'(ifa.out_valid), 32'h0);
        chk("midrst_cnt",   32'(ifa.word_cnt),  32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat_a(8'h55, 1'b0, 1'b0);
        chk("postrst_word", 32'(ifa.out_word), 32'h40);
        chk("postrst_sop",  32'(ifa.out_sop),  32'h1);
        chk("postrst_cnt",  32'(ifa.word_cnt), 32'h1);
        // A sop beat in ACTIVE restarts at once: mode switches to decode,
        // [1,1,1,1] -> [1,2,3,0].
        beat_a(8'h55, 1'b1, 1'b1);
        chk("resop_word", 32'(ifa.out_word), 32'h6C);
        chk("resop_cnt",  32'(ifa.word_cnt), 32'h1);

        // Instance B: [0,1,2,3,4,5,6,7] encodes to [0,1,1,1,1,1,1,1].
        beat_b(24'h053977, 1'b1, 1'b0);
        chk("b_enc_word", 32'(ifb.out_word), 32'h049249);
        chk("b_enc_cnt",  32'(ifb.word_cnt), 32'h1);

        // Loopback: first five words form one sequence (counter saturates at 3),
        // then random split points.
        for (int i = 0; i < 16; i++) begin
            orig[i] = 24'($urandom);
            sopv[i] = (i == 0) || (i >= 5 && $urandom_range(0, 2) == 0);
        end
        ecnt = 0;
        for (int i = 0; i < 16; i++) begin
            beat_b(orig[i], sopv[i], sopv[i] ? 1'b0 : 1'b1);
            ecnt = sopv[i] ? 1 : ((ecnt < 3) ? ecnt + 1 : 3);
            enc[i] = ifb.out_word;
            chk("lb_enc_cnt", 32'(ifb.word_cnt), 32'(ecnt));
            chk("lb_enc_sop", 32'(ifb.out_sop),  32'(sopv[i]));
        end
        for (int i = 0; i < 16; i++) begin
            beat_b(enc[i], sopv[i], sopv[i] ? 1'b1 : 1'b0);
            chk("lb_dec_word", 32'(ifb.out_word), 32'(orig[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
